// File: rtl/alarm_bank.sv
// Multi-channel BCD alarm bank with ring timeout, snooze and cancel.
// Optional hourly chime pulse: define ALARM_BANK_HOURLY_CHIME_EN.
module alarm_bank #(
   parameter int N_ALARM     = 2,
   parameter int RING_SECS   = 60,
   parameter int SNOOZE_SECS = 300,
   localparam int CW = (N_ALARM > 1) ? $clog2(N_ALARM) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               tick_1hz,
   input  logic [1:0]         mode,
   input  logic               key_ch_n,
   input  logic               key_hour_n,
   input  logic               key_min_n,
   input  logic               key_en_n,
   input  logic               key_stop_n,
   input  logic [7:0]         cur_hour,
   input  logic [7:0]         cur_min,
   input  logic [7:0]         cur_sec,
   output logic [CW-1:0]      sel_ch,
   output logic [7:0]         alarm_hour,
   output logic [7:0]         alarm_minute,
   output logic [N_ALARM-1:0] alarm_en,
   output logic               ringing,
   output logic [CW-1:0]      ring_ch,
   output logic               chime
);

   typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

   localparam logic [9:0] RING_LD   = 10'(RING_SECS);
   localparam logic [9:0] SNOOZE_LD = 10'(SNOOZE_SECS);

   state_t     state;
   logic [9:0] cnt;
   logic [4:0] raw, s1, s2, s3, ev;
   logic [7:0] hour   [N_ALARM];
   logic [7:0] minute [N_ALARM];
   logic       hit;
   logic [CW-1:0] hit_ch;
   logic       set_ok;

   function automatic logic [7:0] inc_min(input logic [7:0] v);
      if (v == 8'h59)          return 8'h00;
      else if (v[3:0] == 4'h9) return {v[7:4] + 4'h1, 4'h0};
      else                     return v + 8'h01;
   endfunction

   function automatic logic [7:0] inc_hour(input logic [7:0] v);
      if (v == 8'h23)          return 8'h00;
      else if (v[3:0] == 4'h9) return {v[7:4] + 4'h1, 4'h0};
      else                     return v + 8'h01;
   endfunction

   assign raw    = {key_stop_n, key_en_n, key_min_n, key_hour_n, key_ch_n};
   assign set_ok = (mode == 2'b01);

   // Synchronise keys; the event register fires one clk per falling edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= '1;
         s2 <= '1;
         s3 <= '1;
         ev <= '0;
      end else begin
         s1 <= raw;
         s2 <= s1;
         s3 <= s2;
         ev <= s3 & ~s2;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_ch   <= '0;
         alarm_en <= '0;
         for (int i = 0; i < N_ALARM; i++) begin
            hour[i]   <= 8'h00;
            minute[i] <= 8'h00;
         end
      end else if (set_ok) begin
         if (ev[0])
            sel_ch <= (sel_ch == CW'(N_ALARM - 1)) ? '0 : sel_ch + 1'b1;
         if (ev[1]) hour[sel_ch]   <= inc_hour(hour[sel_ch]);
         if (ev[2]) minute[sel_ch] <= inc_min(minute[sel_ch]);
         if (ev[3]) alarm_en[sel_ch] <= ~alarm_en[sel_ch];
      end
   end

   assign alarm_hour   = hour[sel_ch];
   assign alarm_minute = minute[sel_ch];

   // Descending scan so the lowest matching index is the one kept.
   always_comb begin
      hit    = 1'b0;
      hit_ch = '0;
      for (int i = N_ALARM - 1; i >= 0; i--) begin
         if (tick_1hz && alarm_en[i] && cur_sec == 8'h00 &&
             cur_hour == hour[i] && cur_min == minute[i]) begin
            hit    = 1'b1;
            hit_ch = CW'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         ringing <= 1'b0;
         ring_ch <= '0;
      end else begin
         case (state)
            IDLE: if (hit) begin
               state   <= RING;
               ring_ch <= hit_ch;
               cnt     <= RING_LD;
               ringing <= 1'b1;
            end
            RING: if (!alarm_en[ring_ch]) begin
               state   <= IDLE;
               cnt     <= '0;
               ringing <= 1'b0;
            end else if (ev[4]) begin
               state   <= SNOOZE;
               cnt     <= SNOOZE_LD;
               ringing <= 1'b0;
            end else if (tick_1hz) begin
               if (cnt <= 10'd1) begin
                  state   <= IDLE;
                  cnt     <= '0;
                  ringing <= 1'b0;
               end else begin
                  cnt <= cnt - 10'd1;
               end
            end
            SNOOZE: if (!alarm_en[ring_ch] || ev[4]) begin
               state <= IDLE;
               cnt   <= '0;
            end else if (tick_1hz) begin
               if (cnt <= 10'd1) begin
                  state   <= RING;
                  cnt     <= RING_LD;
                  ringing <= 1'b1;
               end else begin
                  cnt <= cnt - 10'd1;
               end
            end
            default: begin
               state   <= IDLE;
               cnt     <= '0;
               ringing <= 1'b0;
            end
         endcase
      end
   end

`ifdef ALARM_BANK_HOURLY_CHIME_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) chime <= 1'b0;
      else        chime <= tick_1hz && cur_min == 8'h00 && cur_sec == 8'h00;
   end
`else
   assign chime = 1'b0;
`endif

endmodule

// File: tb/tb_alarm_bank.sv
// Bench for alarm_bank: time-based reference model plus directed checks.
// Model keeps alarms as integers and the ring as "ticks remaining".
module tb_alarm_bank;

   localparam int RS = 60;
   localparam int SS = 300;
`ifdef ALARM_BANK_HOURLY_CHIME_EN
   localparam logic CH_EXP = 1'b1;
`else
   localparam logic CH_EXP = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       tick_1hz;
   logic [1:0] mode;
   logic [4:0] keys_n;
   logic [7:0] cur_hour, cur_min, cur_sec;
   logic       sel_ch;
   logic [7:0] alarm_hour, alarm_minute;
   logic [1:0] alarm_en;
   logic       ringing;
   logic       ring_ch;
   logic       chime;

   int total = 0;
   int bad   = 0;

   alarm_bank #(.N_ALARM(2), .RING_SECS(RS), .SNOOZE_SECS(SS)) dut (
      .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .mode(mode),
      .key_ch_n(keys_n[0]), .key_hour_n(keys_n[1]),
      .key_min_n(keys_n[2]), .key_en_n(keys_n[3]),
      .key_stop_n(keys_n[4]),
      .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
      .sel_ch(sel_ch), .alarm_hour(alarm_hour),
      .alarm_minute(alarm_minute), .alarm_en(alarm_en),
      .ringing(ringing), .ring_ch(ring_ch), .chime(chime)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] bcd(input int v);
      return 8'(((v / 10) << 4) + (v % 10));
   endfunction

   // Reference model
   int   m_hour [2];
   int   m_min  [2];
   logic [1:0] m_en;
   int   m_sel, m_st, m_ch, m_left;
   logic m_chime;
   logic [4:0] r1, r2, r3, r4, m_ev;
   int   m_found;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            m_hour[i] = 0;
            m_min[i]  = 0;
         end
         m_en = 2'b00; m_sel = 0; m_st = 0; m_ch = 0; m_left = 0;
         m_chime = 1'b0;
         r1 = '1; r2 = '1; r3 = '1; r4 = '1;
      end else begin
         // a key press acts 3 clocks after the raw level falls
         m_ev = r4 & ~r3;
         if (m_st != 0 && !m_en[m_ch]) begin
            m_st = 0;
         end else if (m_st == 1) begin
            if (m_ev[4]) begin
               m_st = 2; m_left = SS;
            end else if (tick_1hz) begin
               m_left--;
               if (m_left == 0) m_st = 0;
            end
         end else if (m_st == 2) begin
            if (m_ev[4]) m_st = 0;
            else if (tick_1hz) begin
               m_left--;
               if (m_left == 0) begin
                  m_st = 1; m_left = RS;
               end
            end
         end else begin
            m_found = -1;
            for (int i = 0; i < 2; i++)
               if (m_found < 0 && tick_1hz && m_en[i] && cur_sec == 8'h00 &&
                   bcd(m_hour[i]) == cur_hour && bcd(m_min[i]) == cur_min)
                  m_found = i;
            if (m_found >= 0) begin
               m_st = 1; m_ch = m_found; m_left = RS;
            end
         end
         if (mode == 2'b01) begin
            int s;
            s = m_sel;
            if (m_ev[0]) m_sel = (m_sel + 1) % 2;
            if (m_ev[1]) m_hour[s] = (m_hour[s] + 1) % 24;
            if (m_ev[2]) m_min[s]  = (m_min[s] + 1) % 60;
            if (m_ev[3]) m_en[s]   = ~m_en[s];
         end
         m_chime = CH_EXP & tick_1hz & (cur_min == 8'h00) & (cur_sec == 8'h00);
         r4 = r3; r3 = r2; r2 = r1; r1 = keys_n;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("m_sel",  sel_ch, m_sel[0]);
         chk("m_hour", alarm_hour, bcd(m_hour[m_sel]));
         chk("m_min",  alarm_minute, bcd(m_min[m_sel]));
         chk("m_en",   alarm_en, m_en);
         chk("m_ring", ringing, m_st == 1);
         chk("m_rch",  ring_ch, m_ch[0]);
         chk("m_chime", chime, m_chime);
      end
   end

   task automatic press(input int k);
      @(negedge clk);
      keys_n[k] = 1'b0;
      repeat (2) @(negedge clk);
      keys_n[k] = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic tick(input logic [7:0] h, input logic [7:0] m,
                       input logic [7:0] s);
      @(negedge clk);
      cur_hour = h; cur_min = m; cur_sec = s;
      tick_1hz = 1'b1;
      @(negedge clk);
      tick_1hz = 1'b0;
   endtask

   task automatic idle_ticks(input int n);
      for (int i = 0; i < n; i++) tick(8'h12, 8'h34, 8'h56);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      mode = 2'b00;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b1; tick_1hz = 1'b0; mode = 2'b00; keys_n = '1;
      cur_hour = 8'h00; cur_min = 8'h00; cur_sec = 8'h01;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_sel", sel_ch, 1'b0);
      chk("rst_hour", alarm_hour, 8'h00);
      chk("rst_min", alarm_minute, 8'h00);
      chk("rst_en", alarm_en, 2'b00);
      chk("rst_ring", ringing, 1'b0);
      chk("rst_rch", ring_ch, 1'b0);
      chk("rst_chime", chime, 1'b0);
      rst_n = 1'b1;

      // minute walk
      mode = 2'b01;
      for (int i = 1; i <= 60; i++) begin
         press(2);
         chk("min_nib", alarm_minute[3:0] > 4'h9, 1'b0);
         if (i == 10) chk("min_10", alarm_minute, 8'h10);
         if (i == 59) chk("min_59", alarm_minute, 8'h59);
      end
      chk("min_wrap", alarm_minute, 8'h00);

      // hour walk
      for (int i = 1; i <= 24; i++) begin
         press(1);
         if (i == 9)  chk("hr_09", alarm_hour, 8'h09);
         if (i == 10) chk("hr_10", alarm_hour, 8'h10);
         if (i == 20) chk("hr_20", alarm_hour, 8'h20);
         if (i == 23) chk("hr_23", alarm_hour, 8'h23);
      end
      chk("hr_wrap", alarm_hour, 8'h00);

      // run mode ignores edit keys
      mode = 2'b00;
      press(1); press(2); press(3); press(0);
      chk("run_hr", alarm_hour, 8'h00);
      chk("run_min", alarm_minute, 8'h00);
      chk("run_en", alarm_en, 2'b00);
      chk("run_sel", sel_ch, 1'b0);

      // ch0 07:30 rings for RS ticks
      do_reset();
      mode = 2'b01;
      repeat (7) press(1);
      repeat (30) press(2);
      press(3);
      mode = 2'b00;
      chk("set_hr", alarm_hour, 8'h07);
      chk("set_min", alarm_minute, 8'h30);
      chk("set_en", alarm_en, 2'b01);
      press(4);
      chk("stop_idle", ringing, 1'b0);
      tick(8'h07, 8'h30, 8'h00);
      chk("ring_on", ringing, 1'b1);
      chk("ring_ch0", ring_ch, 1'b0);
      idle_ticks(RS - 1);
      chk("ring_last", ringing, 1'b1);
      idle_ticks(1);
      chk("ring_off", ringing, 1'b0);

      // both channels at 06:00, snooze and cancel
      do_reset();
      mode = 2'b01;
      repeat (6) press(1);
      press(3);
      press(0);
      repeat (6) press(1);
      press(3);
      mode = 2'b00;
      chk("both_en", alarm_en, 2'b11);
      tick(8'h06, 8'h00, 8'h00);
      chk("low_wins", ring_ch, 1'b0);
      chk("both_ring", ringing, 1'b1);
      press(4);
      chk("snooze", ringing, 1'b0);
      idle_ticks(SS - 1);
      chk("snz_wait", ringing, 1'b0);
      idle_ticks(1);
      chk("re_ring", ringing, 1'b1);
      press(4);
      idle_ticks(5);
      press(4);
      chk("cancel", ringing, 1'b0);
      idle_ticks(SS + 2);
      chk("cancel_hold", ringing, 1'b0);

      // ch1 disable mid-ring, then async reset mid-ring
      do_reset();
      mode = 2'b01;
      press(0);
      repeat (8) press(1);
      press(3);
      mode = 2'b00;
      tick(8'h08, 8'h00, 8'h00);
      chk("ch1_ring", ringing, 1'b1);
      chk("ch1_rch", ring_ch, 1'b1);
      mode = 2'b01;
      press(3);
      chk("dis_stop", ringing, 1'b0);
      press(3);
      mode = 2'b00;
      tick(8'h08, 8'h00, 8'h00);
      chk("ch1_again", ringing, 1'b1);
      idle_ticks(3);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_ring", ringing, 1'b0);
      chk("ar_rch", ring_ch, 1'b0);
      chk("ar_sel", sel_ch, 1'b0);
      chk("ar_en", alarm_en, 2'b00);
      chk("ar_hr", alarm_hour, 8'h00);
      chk("ar_chime", chime, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // hourly chime
      tick(8'h10, 8'h00, 8'h00);
      chk("chime_top", chime, CH_EXP);
      @(negedge clk);
      chk("chime_1clk", chime, 1'b0);
      tick(8'h10, 8'h00, 8'h01);
      chk("chime_s01", chime, 1'b0);
      chk("chime_noring", ringing, 1'b0);
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
